regfile_wr_arbiter: RTL and testbench

Shares the single register-file write port (WE/WA/WD) between two write requesters: the writeback path (req0) and an auxiliary writer such as a load/debug unit (req1).
- Uses valid/ready handshakes with round-robin arbitration when both requesters contend.
- Includes a clear sequencer that zeroes every writable register, one per cycle, on command.
- Drives the register file write port directly through registered outputs.

---
 rtl/regfile_wr_arbiter.sv | 98 +++++++++
 tb/tb_regfile_wr_arbiter.sv | 202 ++++++++++++++++++++
 2 files changed

// File: rtl/regfile_wr_arbiter.sv
// Register-file write-port arbiter.
// Two requesters share one write port through valid/ready handshakes with
// round-robin arbitration. A clear sequencer can take the port to zero
// registers 1..N-1, one per cycle. Write-port outputs are registered.
module regfile_wr_arbiter #(
    parameter int unsigned DATA = 32,
    parameter int unsigned ADDR = 5
) (
    input  logic            clk,
    input  logic            rstn,
    input  logic            req0_valid,
    input  logic [ADDR-1:0] req0_addr,
    input  logic [DATA-1:0] req0_data,
    output logic            req0_ready,
    input  logic            req1_valid,
    input  logic [ADDR-1:0] req1_addr,
    input  logic [DATA-1:0] req1_data,
    output logic            req1_ready,
    input  logic            clr_start,
    output logic            clr_busy,
    output logic            WE,
    output logic [ADDR-1:0] WA,
    output logic [DATA-1:0] WD,
    output logic            last_grant
);

    typedef enum logic [0:0] {StArb, StClear} state_e;

    state_e state_q;
    // Index of the requester preferred on the next contended cycle.
    logic   ptr_q;
    logic   arb_open;

    // Grant one requester per cycle; clear traffic blocks every handshake.
    always_comb begin
        arb_open   = (state_q == StArb) && !clr_start;
        req0_ready = arb_open && req0_valid && (!req1_valid || (ptr_q == 1'b0));
        req1_ready = arb_open && req1_valid && (!req0_valid || (ptr_q == 1'b1));
    end

    // Arbitration / clear FSM with registered write-port outputs.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_q    <= StArb;
            ptr_q      <= 1'b0;
            WE         <= 1'b0;
            WA         <= '0;
            WD         <= '0;
            clr_busy   <= 1'b0;
            last_grant <= 1'b0;
        end else begin
            unique case (state_q)
                StArb: begin
                    if (clr_start) begin
                        state_q  <= StClear;
                        WE       <= 1'b1;
                        WA       <= ADDR'(1);
                        WD       <= '0;
                        clr_busy <= 1'b1;
                    end else if (req0_ready) begin
                        // Register 0 is hard-wired zero: accept, but suppress the strobe.
                        WE         <= (req0_addr != '0);
                        if (req0_addr != '0) begin
                            WA <= req0_addr;
                            WD <= req0_data;
                        end
                        last_grant <= 1'b0;
                        ptr_q      <= 1'b1;
                    end else if (req1_ready) begin
                        WE         <= (req1_addr != '0);
                        if (req1_addr != '0) begin
                            WA <= req1_addr;
                            WD <= req1_data;
                        end
                        last_grant <= 1'b1;
                        ptr_q      <= 1'b0;
                    end else begin
                        WE <= 1'b0;
                    end
                end
                StClear: begin
                    // Stop after the last register; WA never wraps back to 0.
                    if (WA == {ADDR{1'b1}}) begin
                        state_q  <= StArb;
                        WE       <= 1'b0;
                        clr_busy <= 1'b0;
                    end else begin
                        WE <= 1'b1;
                        WA <= WA + ADDR'(1);
                        WD <= '0;
                    end
                end
                default: state_q <= StArb;
            endcase
        end
    end

endmodule

// File: tb/tb_regfile_wr_arbiter.sv
// Bench for regfile_wr_arbiter: directed scenarios plus randomized traffic,
// compared cycle by cycle against a transaction-level reference model.
module tb_regfile_wr_arbiter;

    localparam int unsigned DATA = 32;
    localparam int unsigned ADDR = 5;
    localparam int N = 1 << ADDR;

    logic            clk = 1'b0;
    logic            rstn = 1'b0;
    logic            req0_valid = 1'b0;
    logic [ADDR-1:0] req0_addr = '0;
    logic [DATA-1:0] req0_data = '0;
    logic            req0_ready;
    logic            req1_valid = 1'b0;
    logic [ADDR-1:0] req1_addr = '0;
    logic [DATA-1:0] req1_data = '0;
    logic            req1_ready;
    logic            clr_start = 1'b0;
    logic            clr_busy;
    logic            WE;
    logic [ADDR-1:0] WA;
    logic [DATA-1:0] WD;
    logic            last_grant;

    regfile_wr_arbiter #(.DATA(DATA), .ADDR(ADDR)) dut (
        .clk        (clk),
        .rstn       (rstn),
        .req0_valid (req0_valid),
        .req0_addr  (req0_addr),
        .req0_data  (req0_data),
        .req0_ready (req0_ready),
        .req1_valid (req1_valid),
        .req1_addr  (req1_addr),
        .req1_data  (req1_data),
        .req1_ready (req1_ready),
        .clr_start  (clr_start),
        .clr_busy   (clr_busy),
        .WE         (WE),
        .WA         (WA),
        .WD         (WD),
        .last_grant (last_grant)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    // Reference model: expected registered outputs after the last edge.
    bit            m_clr;
    int            m_clr_next;   // next register the clear will write
    logic          m_we;
    int            m_wa;
    logic [DATA-1:0] m_wd;
    logic          m_busy;
    int            m_lg;
    int            m_ptr;        // requester preferred when both are valid

    // Requester-side stimulus state (held until accepted).
    logic            p0_v, p1_v, clr_pulse;
    logic [ADDR-1:0] p0_a, p1_a;
    logic [DATA-1:0] p0_d, p1_d;

    task automatic model_reset();
        m_clr = 0; m_clr_next = 0; m_we = 0; m_wa = 0; m_wd = '0;
        m_busy = 0; m_lg = 0; m_ptr = 0;
    endtask

    // One clock: drive, check at negedge, advance model, pass the rising edge.
    task automatic cycle();
        bit e0, e1;
        int ga;
        logic [DATA-1:0] gd;
        req0_valid = p0_v; req0_addr = p0_a; req0_data = p0_d;
        req1_valid = p1_v; req1_addr = p1_a; req1_data = p1_d;
        clr_start  = clr_pulse;
        @(negedge clk);
        e0 = !m_clr && !clr_pulse && p0_v && (!p1_v || m_ptr == 0);
        e1 = !m_clr && !clr_pulse && p1_v && (!p0_v || m_ptr == 1);
        check_val("req0_ready", req0_ready, e0);
        check_val("req1_ready", req1_ready, e1);
        check_val("WE", WE, m_we);
        check_val("WA", WA, m_wa);
        check_val("WD", WD, m_wd);
        check_val("clr_busy", clr_busy, m_busy);
        check_val("last_grant", last_grant, m_lg);
        if (m_clr) begin
            if (m_clr_next < N) begin
                m_we = 1; m_wa = m_clr_next; m_wd = '0; m_clr_next++;
            end else begin
                m_we = 0; m_busy = 0; m_clr = 0;
            end
        end else if (clr_pulse) begin
            m_clr = 1; m_busy = 1; m_we = 1; m_wa = 1; m_wd = '0; m_clr_next = 2;
        end else if (e0 || e1) begin
            ga = e1 ? int'(p1_a) : int'(p0_a);
            gd = e1 ? p1_d : p0_d;
            m_lg = e1 ? 1 : 0;
            m_ptr = e1 ? 0 : 1;
            m_we = (ga != 0);
            if (ga != 0) begin
                m_wa = ga; m_wd = gd;
            end
        end else begin
            m_we = 0;
        end
        if (e0) p0_v = 0;
        if (e1) p1_v = 0;
        clr_pulse = 0;
        @(posedge clk);
        #1;
    endtask

    // Asynchronous reset applied between clock edges.
    task automatic do_reset();
        rstn = 1'b0;
        p0_v = 0; p1_v = 0; clr_pulse = 0;
        req0_valid = 0; req1_valid = 0; clr_start = 0;
        #2;
        check_val("rst_WE", WE, 0);
        check_val("rst_WA", WA, 0);
        check_val("rst_WD", WD, 0);
        check_val("rst_busy", clr_busy, 0);
        check_val("rst_last_grant", last_grant, 0);
        model_reset();
        @(negedge clk);
        rstn = 1'b1;
        @(posedge clk);
        #1;
    endtask

    initial begin
        p0_v = 0; p1_v = 0; clr_pulse = 0;
        p0_a = '0; p1_a = '0; p0_d = '0; p1_d = '0;
        model_reset();
        #3;
        do_reset();

        // 1: single req0 write
        p0_v = 1; p0_a = 5'd3; p0_d = 32'h11;
        for (int i = 0; i < 3; i++) cycle();

        // 2: contention, grants alternate starting from req0
        do_reset();
        p0_v = 1; p0_a = 5'd2; p0_d = 32'hA;
        p1_v = 1; p1_a = 5'd4; p1_d = 32'hB;
        for (int i = 0; i < 4; i++) cycle();

        // 3: write to register 0 is accepted but never strobed
        p1_v = 1; p1_a = 5'd0; p1_d = 32'h55;
        for (int i = 0; i < 3; i++) cycle();
        check_val("addr0_last_grant", last_grant, 1);

        // 4: clear while req0 waits; a second clr_start mid-clear is ignored
        do_reset();
        p0_v = 1; p0_a = 5'd7; p0_d = 32'hCAFE;
        clr_pulse = 1;
        for (int i = 0; i < 36; i++) begin
            if (i == 10) clr_pulse = 1;
            cycle();
        end

        // 5: reset in the middle of a clear, then req0 wins with pointer back at 0
        do_reset();
        p0_v = 1; p0_a = 5'd9; p0_d = 32'h99;
        cycle();
        clr_pulse = 1;
        cycle();
        for (int i = 0; i < 9; i++) cycle();
        check_val("mid_clear_WA", WA, 10);
        do_reset();
        p0_v = 1; p0_a = 5'd6; p0_d = 32'h66;
        p1_v = 1; p1_a = 5'd8; p1_d = 32'h88;
        cycle();
        for (int i = 0; i < 3; i++) cycle();

        // Randomized traffic with held requests and occasional clears
        for (int k = 0; k < 3000; k++) begin
            if (!p0_v && ($urandom % 3 != 0)) begin
                p0_v = 1; p0_a = ADDR'($urandom); p0_d = $urandom;
            end
            if (!p1_v && ($urandom % 3 != 0)) begin
                p1_v = 1; p1_a = ADDR'($urandom); p1_d = $urandom;
            end
            if ($urandom % 150 == 0) clr_pulse = 1;
            cycle();
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
